// File: rtl/usb2_ep_in_packer.sv
// usb2_ep_in_packer
// Packs a byte stream into USB IN endpoint buffer packets. Bytes are written
// straight through to the endpoint buffer with no added latency. A packet is
// committed when it fills to MAX_PKT, when the stream marks its last byte, or
// when a partial packet has sat idle for FLUSH_CYC cycles.

module usb2_ep_in_packer #(
  parameter int MAX_PKT   = 1024,
  parameter int FLUSH_CYC = 4096
) (
  input  logic        phy_clk,
  input  logic        reset_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [10:0] buf_in_addr,
  output logic [7:0]  buf_in_data,
  output logic        buf_in_wren,
  input  logic        buf_in_ready,
  output logic        buf_in_commit,
  output logic [10:0] buf_in_commit_len,
  input  logic        buf_in_commit_ack,
  output logic [15:0] pkt_count,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_COMMIT,
    ST_ACK_WAIT
  } state_t;

  // The idle timer saturates one below FLUSH_CYC: the flush fires on the
  // idle cycle that would bring the count up to FLUSH_CYC.
  localparam int TW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [TW-1:0] TIMER_TOP = (FLUSH_CYC > 0) ? TW'(FLUSH_CYC - 1) : {TW{1'b0}};
  localparam logic [10:0]   MAX_LEN   = 11'(MAX_PKT);

  state_t        state;
  state_t        state_next;
  logic [10:0]   cnt;
  logic [TW-1:0] idle_timer;
  logic          xfer;
  logic          pkt_full;
  logic          last_hit;
  logic          flush_hit;
  logic          end_pkt;

  // Stream handshake and packet-end conditions evaluated while filling
  assign xfer      = s_valid && s_ready;
  assign pkt_full  = xfer && ((cnt + 11'd1) == MAX_LEN);
  assign last_hit  = xfer && s_last;
  assign flush_hit = (FLUSH_CYC > 0) && !xfer && (cnt != 11'd0) && (idle_timer == TIMER_TOP);
  assign end_pkt   = pkt_full || last_hit || flush_hit;

  // Buffer write port follows the stream directly; address is the fill count
  assign buf_in_wren = xfer;
  assign buf_in_addr = cnt;
  assign buf_in_data = s_data;

  // State register
  always_ff @(posedge phy_clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: claim a free half-buffer, fill it, then run the commit handshake
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (buf_in_ready)       state_next = ST_FILL;
      ST_FILL:     if (end_pkt)            state_next = ST_COMMIT;
      ST_COMMIT:   if (buf_in_commit_ack)  state_next = ST_ACK_WAIT;
      ST_ACK_WAIT: if (!buf_in_commit_ack) state_next = ST_IDLE;
      default:                             state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs: accept bytes only while filling with room left
  always_comb begin
    s_ready       = 1'b0;
    buf_in_commit = 1'b0;
    busy          = (state != ST_IDLE);
    case (state)
      ST_FILL:   s_ready       = (cnt < MAX_LEN);
      ST_COMMIT: buf_in_commit = 1'b1;
      default: ;
    endcase
  end

  // Byte counter, idle timer, committed length and packet counter
  always_ff @(posedge phy_clk) begin
    if (!reset_n) begin
      cnt               <= 11'd0;
      idle_timer        <= {TW{1'b0}};
      buf_in_commit_len <= 11'd0;
      pkt_count         <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (buf_in_ready) begin
            cnt        <= 11'd0;
            idle_timer <= {TW{1'b0}};
          end
        end
        ST_FILL: begin
          if (xfer) begin
            cnt        <= cnt + 11'd1;
            idle_timer <= {TW{1'b0}};
          end else if (idle_timer != TIMER_TOP) begin
            idle_timer <= idle_timer + 1'b1;
          end
          if (end_pkt) begin
            buf_in_commit_len <= xfer ? (cnt + 11'd1) : cnt;
          end
        end
        ST_ACK_WAIT: begin
          if (!buf_in_commit_ack) begin
            pkt_count <= pkt_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb2_ep_in_packer.sv
// Directed testbench for usb2_ep_in_packer (MAX_PKT=1024, FLUSH_CYC=16).
// Inputs change 1 time unit after the falling edge; outputs are sampled
// shortly after that, well clear of the rising edge.

module tb_usb2_ep_in_packer;

  logic        phy_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [10:0] buf_in_addr;
  logic [7:0]  buf_in_data;
  logic        buf_in_wren;
  logic        buf_in_ready = 1'b0;
  logic        buf_in_commit;
  logic [10:0] buf_in_commit_len;
  logic        buf_in_commit_ack = 1'b0;
  logic [15:0] pkt_count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  usb2_ep_in_packer #(.MAX_PKT(1024), .FLUSH_CYC(16)) dut (
    .phy_clk(phy_clk), .reset_n(reset_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
    .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
    .pkt_count(pkt_count), .busy(busy)
  );

  // Free-running clock
  always #5 phy_clk = ~phy_clk;

  // Advance to the drive point of the next cycle
  task automatic next_cycle();
    @(negedge phy_clk);
    #1;
  endtask

  // Wait, within a cycle budget, for the packer to accept bytes
  task automatic wait_for_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      next_cycle();
      if (s_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; buf_in_ready = 1'b0; buf_in_commit_ack = 1'b0; s_valid = 1'b0;
    repeat (3) next_cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_s_ready: got %b expected 0", s_ready); end
    n_checks++; if (buf_in_commit !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_commit: got %b expected 0", buf_in_commit); end
    n_checks++; if (buf_in_commit_len !== 11'd0) begin n_fail++; $display("[TB] FAIL rst_len: got %0d expected 0", buf_in_commit_len); end
    n_checks++; if (pkt_count !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_pkt_count: got %0d expected 0", pkt_count); end
    n_checks++; if (buf_in_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_wren: got %b expected 0", buf_in_wren); end
    n_checks++; if (buf_in_addr !== 11'd0) begin n_fail++; $display("[TB] FAIL rst_addr: got %0d expected 0", buf_in_addr); end
    reset_n = 1'b1;
    next_cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_no_buf_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_packet();
    bit ok;
    buf_in_ready = 1'b1;
    wait_for_ready(10, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL full_enter_fill: got %b expected 1", ok); end
    for (int i = 0; i < 1024; i++) begin
      s_valid = 1'b1; s_data = 8'(i) ^ 8'h5A; s_last = (i == 1023);
      #1;
      n_checks++; if (buf_in_wren !== 1'b1) begin n_fail++; $display("[TB] FAIL full_wren[%0d]: got %b expected 1", i, buf_in_wren); end
      n_checks++; if (buf_in_addr !== 11'(i)) begin n_fail++; $display("[TB] FAIL full_addr[%0d]: got %0d expected %0d", i, buf_in_addr, i); end
      n_checks++; if (buf_in_data !== (8'(i) ^ 8'h5A)) begin n_fail++; $display("[TB] FAIL full_data[%0d]: got %h expected %h", i, buf_in_data, 8'(i) ^ 8'h5A); end
      next_cycle();
    end
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    n_checks++; if (buf_in_commit !== 1'b1) begin n_fail++; $display("[TB] FAIL full_commit: got %b expected 1", buf_in_commit); end
    n_checks++; if (buf_in_commit_len !== 11'd1024) begin n_fail++; $display("[TB] FAIL full_len: got %0d expected 1024", buf_in_commit_len); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_s_ready: got %b expected 0", s_ready); end
    next_cycle();
    n_checks++; if (buf_in_commit !== 1'b1) begin n_fail++; $display("[TB] FAIL full_commit_hold: got %b expected 1", buf_in_commit); end
    buf_in_commit_ack = 1'b1;
    next_cycle();
    n_checks++; if (buf_in_commit !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ackwait_commit: got %b expected 0", buf_in_commit); end
    n_checks++; if (pkt_count !== 16'd0) begin n_fail++; $display("[TB] FAIL full_pkt_early: got %0d expected 0", pkt_count); end
    buf_in_commit_ack = 1'b0;
    next_cycle();
    n_checks++; if (pkt_count !== 16'd1) begin n_fail++; $display("[TB] FAIL full_pkt_count: got %0d expected 1", pkt_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL full_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_last_packet();
    bit ok;
    wait_for_ready(5, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL last_enter_fill: got %b expected 1", ok); end
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'h10 + 8'(i); s_last = (i == 4);
      #1;
      n_checks++; if (buf_in_addr !== 11'(i)) begin n_fail++; $display("[TB] FAIL last_addr[%0d]: got %0d expected %0d", i, buf_in_addr, i); end
      next_cycle();
    end
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    n_checks++; if (buf_in_commit !== 1'b1) begin n_fail++; $display("[TB] FAIL last_commit: got %b expected 1", buf_in_commit); end
    n_checks++; if (buf_in_commit_len !== 11'd5) begin n_fail++; $display("[TB] FAIL last_len: got %0d expected 5", buf_in_commit_len); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL last_s_ready_commit: got %b expected 0", s_ready); end
    buf_in_commit_ack = 1'b1;
    next_cycle();
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL last_s_ready_ackwait: got %b expected 0", s_ready); end
    buf_in_commit_ack = 1'b0;
    next_cycle();
    n_checks++; if (pkt_count !== 16'd2) begin n_fail++; $display("[TB] FAIL last_pkt_count: got %0d expected 2", pkt_count); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL last_s_ready_idle: got %b expected 0", s_ready); end
    next_cycle();
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL last_s_ready_refill: got %b expected 1", s_ready); end
  endtask

  task automatic test_flush();
    // Empty packet: the timer may expire but nothing may be committed
    s_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      n_checks++; if (buf_in_commit !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_empty_commit[%0d]: got %b expected 0", c, buf_in_commit); end
    end
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'hA0 + 8'(i); s_last = 1'b0;
      #1;
      n_checks++; if (buf_in_addr !== 11'(i)) begin n_fail++; $display("[TB] FAIL flush_addr[%0d]: got %0d expected %0d", i, buf_in_addr, i); end
      next_cycle();
    end
    s_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      #1;
      n_checks++; if (buf_in_commit !== (k == 17)) begin n_fail++; $display("[TB] FAIL flush_commit_k%0d: got %b expected %b", k, buf_in_commit, (k == 17)); end
      if (k < 17) next_cycle();
    end
    n_checks++; if (buf_in_commit_len !== 11'd3) begin n_fail++; $display("[TB] FAIL flush_len: got %0d expected 3", buf_in_commit_len); end
    buf_in_ready = 1'b0;
    buf_in_commit_ack = 1'b1;
    next_cycle();
    buf_in_commit_ack = 1'b0;
    next_cycle();
    n_checks++; if (pkt_count !== 16'd3) begin n_fail++; $display("[TB] FAIL flush_pkt_count: got %0d expected 3", pkt_count); end
  endtask

  task automatic test_not_ready();
    bit ok;
    s_valid = 1'b1; s_data = 8'hC3; s_last = 1'b0;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL nrdy_s_ready[%0d]: got %b expected 0", c, s_ready); end
      n_checks++; if (buf_in_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL nrdy_wren[%0d]: got %b expected 0", c, buf_in_wren); end
    end
    buf_in_ready = 1'b1;
    wait_for_ready(5, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL nrdy_enter_fill: got %b expected 1", ok); end
    n_checks++; if (buf_in_wren !== 1'b1) begin n_fail++; $display("[TB] FAIL nrdy_first_wren: got %b expected 1", buf_in_wren); end
    n_checks++; if (buf_in_addr !== 11'd0) begin n_fail++; $display("[TB] FAIL nrdy_first_addr: got %0d expected 0", buf_in_addr); end
    next_cycle();
    s_data = 8'h3C; s_last = 1'b1;
    #1;
    n_checks++; if (buf_in_addr !== 11'd1) begin n_fail++; $display("[TB] FAIL nrdy_second_addr: got %0d expected 1", buf_in_addr); end
    next_cycle();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_ack_delay();
    #1;
    n_checks++; if (buf_in_commit !== 1'b1) begin n_fail++; $display("[TB] FAIL ackd_commit: got %b expected 1", buf_in_commit); end
    n_checks++; if (buf_in_commit_len !== 11'd2) begin n_fail++; $display("[TB] FAIL ackd_len: got %0d expected 2", buf_in_commit_len); end
    for (int c = 0; c < 50; c++) begin
      next_cycle();
      n_checks++; if (buf_in_commit !== 1'b1) begin n_fail++; $display("[TB] FAIL ackd_commit_hold[%0d]: got %b expected 1", c, buf_in_commit); end
      n_checks++; if (buf_in_commit_len !== 11'd2) begin n_fail++; $display("[TB] FAIL ackd_len_hold[%0d]: got %0d expected 2", c, buf_in_commit_len); end
    end
    buf_in_commit_ack = 1'b1;
    next_cycle();
    n_checks++; if (pkt_count !== 16'd3) begin n_fail++; $display("[TB] FAIL ackd_pkt_early: got %0d expected 3", pkt_count); end
    buf_in_commit_ack = 1'b0;
    next_cycle();
    n_checks++; if (pkt_count !== 16'd4) begin n_fail++; $display("[TB] FAIL ackd_pkt_count: got %0d expected 4", pkt_count); end
    next_cycle();
    n_checks++; if (pkt_count !== 16'd4) begin n_fail++; $display("[TB] FAIL ackd_pkt_once: got %0d expected 4", pkt_count); end
    n_checks++; if (buf_in_commit_len !== 11'd2) begin n_fail++; $display("[TB] FAIL ackd_len_after: got %0d expected 2", buf_in_commit_len); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_data = 8'h70 + 8'(i); s_last = 1'b0;
      #1;
      n_checks++; if (buf_in_addr !== 11'(i)) begin n_fail++; $display("[TB] FAIL rmid_addr[%0d]: got %0d expected %0d", i, buf_in_addr, i); end
      next_cycle();
    end
    s_valid = 1'b0;
    reset_n = 1'b0;
    next_cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
    n_checks++; if (buf_in_addr !== 11'd0) begin n_fail++; $display("[TB] FAIL rmid_cnt: got %0d expected 0", buf_in_addr); end
    n_checks++; if (pkt_count !== 16'd0) begin n_fail++; $display("[TB] FAIL rmid_pkt_count: got %0d expected 0", pkt_count); end
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (buf_in_commit !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_commit[%0d]: got %b expected 0", c, buf_in_commit); end
      if (c == 1) reset_n = 1'b1;
      next_cycle();
    end
    wait_for_ready(5, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_enter_fill: got %b expected 1", ok); end
    s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b1;
    #1;
    n_checks++; if (buf_in_addr !== 11'd0) begin n_fail++; $display("[TB] FAIL rmid_restart_addr: got %0d expected 0", buf_in_addr); end
    next_cycle();
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    n_checks++; if (buf_in_commit_len !== 11'd1) begin n_fail++; $display("[TB] FAIL rmid_len: got %0d expected 1", buf_in_commit_len); end
    buf_in_commit_ack = 1'b1;
    next_cycle();
    buf_in_commit_ack = 1'b0;
    next_cycle();
    n_checks++; if (pkt_count !== 16'd1) begin n_fail++; $display("[TB] FAIL rmid_pkt_count_after: got %0d expected 1", pkt_count); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_full_packet();
    test_last_packet();
    test_flush();
    test_not_ready();
    test_ack_delay();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Run-time guard against a stalled scenario
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
